// File: rtl/trivium_seed_collector_pkg.sv
// Shared definitions for the Trivium seed collector.
//   params   : default key/IV widths and the repetition-count limit.
//   le_types : state encoding of the seed collection FSM.
// No ports; these packages hold only constants and types.

package params;
    localparam int KEY_WIDTH = 80;
    localparam int IV_WIDTH  = 80;
    localparam int RCT_LIMIT = 32;
endpackage

package le_types;
    typedef enum logic [1:0] {
        COLLECT_KEY = 2'd0,
        COLLECT_IV  = 2'd1,
        HOLD        = 2'd2,
        FAIL        = 2'd3
    } seed_fsm_t;
endpackage

// File: rtl/trivium_seed_collector_vn_extractor.sv
// Von Neumann debiaser. The first bit of each pair is latched and the pair
// flag set; the second bit closes the pair. Pair 01 emits 0 and pair 10
// emits 1 (the latched first bit). Pairs 00 and 11 emit nothing.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   raw_bit    : raw entropy bit
//   raw_valid  : raw_bit is valid this cycle
//   flush      : hold the pair flag at 0 and suppress output
//   out_bit    : debiased bit
//   out_valid  : out_bit is valid this cycle (combinational from pair state)
// The output is combinational so the collector can store the bit on the
// same edge that completes the pair.

module vn_extractor (
    input  logic clk,
    input  logic rst,
    input  logic raw_bit,
    input  logic raw_valid,
    input  logic flush,
    output logic out_bit,
    output logic out_valid
);

    logic pair_r;
    logic first_r;

    // Emit a bit when a valid beat completes a pair of differing bits.
    always_comb begin
        out_bit   = first_r;
        out_valid = 1'b0;
        if (raw_valid && pair_r && !flush && (raw_bit != first_r)) begin
            out_valid = 1'b1;
        end else begin
            out_valid = 1'b0;
        end
    end

    // Pair flag and first-bit latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_r  <= 1'b0;
            first_r <= 1'b0;
        end else if (flush) begin
            pair_r  <= 1'b0;
        end else if (raw_valid) begin
            if (!pair_r) begin
                first_r <= raw_bit;
                pair_r  <= 1'b1;
            end else begin
                pair_r  <= 1'b0;
            end
        end else begin
            pair_r  <= pair_r;
        end
    end

endmodule

// File: rtl/trivium_seed_collector.sv
// Seed collector feeding the Trivium keystream stage. Raw TRNG bits are
// debiased, packed LSB-first into a key then an IV, and the completed seed
// is offered with a valid/ready handshake. A repetition-count health test
// on the raw stream latches a sticky failure and parks the FSM in FAIL.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   raw_bit     : raw entropy bit
//   raw_valid   : raw_bit is valid this cycle
//   seed_ready  : consumer accepts the seed
//   seed_valid  : key_/iv_ hold a complete seed
//   key_        : collected key (KEY_WIDTH bits)
//   iv_         : collected IV (IV_WIDTH bits)
//   health_fail : sticky source-failure flag

module trivium_seed_collector #(
    parameter int KEY_WIDTH = params::KEY_WIDTH,
    parameter int IV_WIDTH  = params::IV_WIDTH,
    parameter int RCT_LIMIT = params::RCT_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 raw_bit,
    input  logic                 raw_valid,
    input  logic                 seed_ready,
    output logic                 seed_valid,
    output logic [KEY_WIDTH-1:0] key_,
    output logic [IV_WIDTH-1:0]  iv_,
    output logic                 health_fail
);

    import le_types::*;

    localparam int MAX_W = (KEY_WIDTH > IV_WIDTH) ? KEY_WIDTH : IV_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);

    seed_fsm_t              state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [KEY_WIDTH-1:0]   key_r;
    logic [IV_WIDTH-1:0]    iv_r;
    logic                   seed_valid_r;
    logic                   health_fail_r;
    logic [RUN_W-1:0]       run_len_r;
    logic                   prev_bit_r;

    logic                   ext_bit_s;
    logic                   ext_valid_s;
    logic                   flush_s;
    logic                   health_active_s;
    logic [RUN_W-1:0]       run_next_s;
    logic                   fail_now_s;

    // Pairing is frozen while a seed is held or the source has failed.
    always_comb begin
        flush_s = 1'b0;
        if ((state_r == HOLD) || (state_r == FAIL)) begin
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    vn_extractor u_vn_extractor (
        .clk       (clk),
        .rst       (rst),
        .raw_bit   (raw_bit),
        .raw_valid (raw_valid),
        .flush     (flush_s),
        .out_bit   (ext_bit_s),
        .out_valid (ext_valid_s)
    );

    // Repetition-count test: a zero run length marks "no previous bit".
    always_comb begin
        health_active_s = raw_valid && (state_r != FAIL);
        run_next_s      = run_len_r;
        fail_now_s      = 1'b0;
        if (health_active_s) begin
            if ((run_len_r == RUN_W'(0)) || (raw_bit != prev_bit_r)) begin
                run_next_s = RUN_W'(1);
            end else if (run_len_r == RUN_W'(RCT_LIMIT)) begin
                run_next_s = run_len_r;
            end else begin
                run_next_s = run_len_r + RUN_W'(1);
            end
            fail_now_s = (run_next_s == RUN_W'(RCT_LIMIT));
        end else begin
            run_next_s = run_len_r;
            fail_now_s = 1'b0;
        end
    end

    // Health-test history.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_len_r  <= RUN_W'(0);
            prev_bit_r <= 1'b0;
        end else if (health_active_s) begin
            run_len_r  <= run_next_s;
            prev_bit_r <= raw_bit;
        end else begin
            run_len_r  <= run_len_r;
        end
    end

    // Collection FSM; a health failure takes priority over any bit write
    // or handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= COLLECT_KEY;
            cnt_r         <= CNT_W'(0);
            key_r         <= {KEY_WIDTH{1'b0}};
            iv_r          <= {IV_WIDTH{1'b0}};
            seed_valid_r  <= 1'b0;
            health_fail_r <= 1'b0;
        end else if (fail_now_s) begin
            state_r       <= FAIL;
            seed_valid_r  <= 1'b0;
            health_fail_r <= 1'b1;
        end else begin
            case (state_r)
                COLLECT_KEY: begin
                    if (ext_valid_s) begin
                        key_r[cnt_r] <= ext_bit_s;
                        if (cnt_r == CNT_W'(KEY_WIDTH - 1)) begin
                            state_r <= COLLECT_IV;
                            cnt_r   <= CNT_W'(0);
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                COLLECT_IV: begin
                    if (ext_valid_s) begin
                        iv_r[cnt_r] <= ext_bit_s;
                        if (cnt_r == CNT_W'(IV_WIDTH - 1)) begin
                            state_r      <= HOLD;
                            cnt_r        <= CNT_W'(0);
                            seed_valid_r <= 1'b1;
                        end else begin
                            cnt_r        <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                HOLD: begin
                    if (seed_ready) begin
                        state_r      <= COLLECT_KEY;
                        cnt_r        <= CNT_W'(0);
                        seed_valid_r <= 1'b0;
                    end else begin
                        seed_valid_r <= 1'b1;
                    end
                end
                FAIL: begin
                    seed_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= FAIL;
                    seed_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign seed_valid  = seed_valid_r;
    assign key_        = key_r;
    assign iv_         = iv_r;
    assign health_fail = health_fail_r;

endmodule

// File: tb/tb_trivium_seed_collector.sv
module tb_trivium_seed_collector;

    localparam int KW  = 80;
    localparam int IW  = 80;
    localparam int RCT = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          raw_bit = 1'b0;
    logic          raw_valid = 1'b0;
    logic          seed_ready = 1'b0;
    logic          seed_valid;
    logic [KW-1:0] key_;
    logic [IW-1:0] iv_;
    logic          health_fail;

    int total = 0;
    int bad   = 0;
    int dut_xfers = 0;

    // Reference model: counts of debiased bits, plain run tracking.
    localparam int M_COLLECT = 0;
    localparam int M_HOLD    = 1;
    localparam int M_FAIL    = 2;
    int            m_mode;
    int            m_n;
    int            m_run;
    int            m_xfers;
    bit            m_seen;
    bit            m_last;
    bit            m_pend;
    bit            m_pb;
    logic          m_valid;
    logic          m_fail;
    logic [KW-1:0] m_key;
    logic [IW-1:0] m_iv;

    trivium_seed_collector dut (
        .clk         (clk),
        .rst         (rst),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .seed_ready  (seed_ready),
        .seed_valid  (seed_valid),
        .key_        (key_),
        .iv_         (iv_),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_COLLECT; m_n = 0; m_run = 0; m_xfers = 0;
        m_seen = 1'b0; m_last = 1'b0; m_pend = 1'b0; m_pb = 1'b0;
        m_valid = 1'b0; m_fail = 1'b0; m_key = '0; m_iv = '0;
    endtask

    task automatic model_edge(input logic rb, input logic rv, input logic rdy);
        bit fail_hit;
        fail_hit = 1'b0;
        if (m_mode != M_FAIL && rv) begin
            if (!m_seen || rb != m_last) m_run = 1;
            else if (m_run < RCT) m_run = m_run + 1;
            m_seen = 1'b1;
            m_last = rb;
            if (m_run >= RCT) fail_hit = 1'b1;
        end
        if (m_valid && rdy) m_xfers++;
        if (fail_hit) begin
            m_mode = M_FAIL; m_fail = 1'b1; m_valid = 1'b0;
        end else if (m_mode == M_HOLD) begin
            if (rdy) begin m_mode = M_COLLECT; m_valid = 1'b0; m_n = 0; end
        end else if (m_mode == M_COLLECT && rv) begin
            if (!m_pend) begin
                m_pend = 1'b1; m_pb = rb;
            end else begin
                m_pend = 1'b0;
                if (m_pb != rb) begin
                    if (m_n < KW) m_key[m_n] = m_pb;
                    else m_iv[m_n-KW] = m_pb;
                    m_n++;
                    if (m_n == KW + IW) begin m_mode = M_HOLD; m_valid = 1'b1; end
                end
            end
        end
    endtask

    task automatic step(input logic rb, input logic rv, input logic rdy);
        raw_bit = rb; raw_valid = rv; seed_ready = rdy;
        if (seed_valid && rdy) dut_xfers++;
        model_edge(rb, rv, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic feed_pair(input logic a, input logic b, input logic rdy);
        step(a, 1'b1, rdy);
        step(b, 1'b1, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1; raw_valid = 1'b0; seed_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({seed_valid, health_fail, key_, iv_} !== {1'b0, 1'b0, 80'h0, 80'h0}) begin
            bad++;
            $display("FAIL reset_values: got v=%0b h=%0b key=%h iv=%h, want all zero", seed_valid, health_fail, key_, iv_);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < KW + IW; i++) begin
            if (i < KW) feed_pair(1'b0, 1'b1, 1'b0);
            else begin
                step(1'b1, 1'b1, 1'b0);
                if (i == KW + IW - 1) begin
                    total++;
                    if (seed_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL basic_early_valid: got %0b want 0", seed_valid);
                    end
                end
                step(1'b0, 1'b1, 1'b0);
            end
            total++;
            if ({seed_valid, health_fail, key_, iv_} !== {m_valid, m_fail, m_key, m_iv}) begin
                bad++;
                $display("FAIL basic_cycle %0d: got v=%0b h=%0b key=%h iv=%h want v=%0b h=%0b key=%h iv=%h",
                         i, seed_valid, health_fail, key_, iv_, m_valid, m_fail, m_key, m_iv);
            end
        end
        total++;
        if ({seed_valid, health_fail, key_, iv_} !== {1'b1, 1'b0, 80'h0, {80{1'b1}}}) begin
            bad++;
            $display("FAIL basic_seed: got v=%0b h=%0b key=%h iv=%h want v=1 h=0 key=0 iv=all ones",
                     seed_valid, health_fail, key_, iv_);
        end
    endtask

    task automatic test_discard();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            feed_pair(1'b1, 1'b0, 1'b0);
            feed_pair(1'b0, 1'b0, 1'b0);
            feed_pair(1'b1, 1'b1, 1'b0);
        end
        total++;
        if ({key_[9:0], key_[KW-1:10], seed_valid} !== {10'h3FF, 70'h0, 1'b0}) begin
            bad++;
            $display("FAIL discard_key: got key=%h v=%0b want key[9:0]=3ff rest 0", key_, seed_valid);
        end
        // The next emitted bit must land at index 10.
        feed_pair(1'b1, 1'b0, 1'b0);
        total++;
        if (key_ !== 80'h7FF) begin
            bad++;
            $display("FAIL discard_counter: got key=%h want 7ff", key_);
        end
    endtask

    task automatic test_hold();
        int cyc;
        logic [KW-1:0] snap_key;
        logic [IW-1:0] snap_iv;
        do_reset();
        cyc = 0;
        while (!m_valid && cyc < 4000) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
            total++;
            if ({seed_valid, health_fail, key_, iv_} !== {m_valid, m_fail, m_key, m_iv}) begin
                bad++;
                $display("FAIL hold_collect: got v=%0b h=%0b key=%h iv=%h want v=%0b h=%0b key=%h iv=%h",
                         seed_valid, health_fail, key_, iv_, m_valid, m_fail, m_key, m_iv);
            end
            cyc++;
        end
        total++;
        if (seed_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_timeout: got v=%0b want 1 within 4000 cycles", seed_valid);
        end
        snap_key = m_key;
        snap_iv  = m_iv;
        for (int i = 0; i < 50; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            total++;
            if ({seed_valid, key_, iv_} !== {1'b1, snap_key, snap_iv}) begin
                bad++;
                $display("FAIL hold_stable: got v=%0b key=%h iv=%h want v=1 key=%h iv=%h",
                         seed_valid, key_, iv_, snap_key, snap_iv);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (seed_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_handshake: got v=%0b want 0", seed_valid);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            total++;
            if ({seed_valid, health_fail, key_, iv_} !== {m_valid, m_fail, m_key, m_iv}) begin
                bad++;
                $display("FAIL hold_recollect: got v=%0b key=%h iv=%h want v=%0b key=%h iv=%h",
                         seed_valid, key_, iv_, m_valid, m_key, m_iv);
            end
        end
    endtask

    task automatic test_health();
        do_reset();
        repeat (31) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (health_fail !== 1'b0) begin
            bad++;
            $display("FAIL health_31_ones: got %0b want 0", health_fail);
        end
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < RCT; i++) begin
            step(1'b0, 1'b1, 1'b0);
            total++;
            if ({health_fail, seed_valid} !== {(i == RCT - 1) ? 1'b1 : 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL health_zero_run %0d: got h=%0b v=%0b", i, health_fail, seed_valid);
            end
        end
        for (int i = 0; i < 200; i++) begin
            step(1'(i[0]), 1'b1, 1'(i[1]));
            total++;
            if ({health_fail, seed_valid} !== {m_fail, m_valid}) begin
                bad++;
                $display("FAIL health_sticky: got h=%0b v=%0b want h=%0b v=%0b", health_fail, seed_valid, m_fail, m_valid);
            end
        end
        do_reset();
        total++;
        if (health_fail !== 1'b0) begin
            bad++;
            $display("FAIL health_rst_clear: got %0b want 0", health_fail);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        logic b;
        do_reset();
        cyc = 0;
        while (m_n < 100 && cyc < 4000) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            cyc++;
        end
        total++;
        if ({key_, iv_} !== {m_key, m_iv}) begin
            bad++;
            $display("FAIL rst_mid_pre: got key=%h iv=%h want key=%h iv=%h", key_, iv_, m_key, m_iv);
        end
        do_reset();
        total++;
        if ({seed_valid, health_fail, key_, iv_} !== {1'b0, 1'b0, 80'h0, 80'h0}) begin
            bad++;
            $display("FAIL rst_mid_zero: got v=%0b h=%0b key=%h iv=%h want all zero", seed_valid, health_fail, key_, iv_);
        end
        for (int i = 0; i < KW + IW; i++) begin
            b = 1'($urandom_range(0, 1));
            feed_pair(b, ~b, 1'b0);
            total++;
            if ({seed_valid, key_, iv_} !== {(i == KW + IW - 1) ? 1'b1 : 1'b0, m_key, m_iv}) begin
                bad++;
                $display("FAIL rst_mid_refill %0d: got v=%0b key=%h iv=%h want key=%h iv=%h",
                         i, seed_valid, key_, iv_, m_key, m_iv);
            end
        end
    endtask

    task automatic test_hold_fail();
        logic b;
        int   x0;
        do_reset();
        b = 1'b0;
        for (int i = 0; i < KW + IW; i++) begin
            b = 1'($urandom_range(0, 1));
            feed_pair(b, ~b, 1'b0);
        end
        total++;
        if (seed_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_fail_setup: got v=%0b want 1", seed_valid);
        end
        x0 = dut_xfers;
        // Last raw bit was ~b, so a run of b starts fresh.
        for (int i = 0; i < RCT; i++) begin
            step(b, 1'b1, (i == RCT - 1) ? 1'b1 : 1'b0);
            total++;
            if ({seed_valid, health_fail, key_, iv_} !== {m_valid, m_fail, m_key, m_iv}) begin
                bad++;
                $display("FAIL hold_fail_cycle %0d: got v=%0b h=%0b want v=%0b h=%0b", i, seed_valid, health_fail, m_valid, m_fail);
            end
        end
        total++;
        if ({dut_xfers - x0, seed_valid, health_fail} !== {32'd1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hold_fail_final: got xfers=%0d v=%0b h=%0b want xfers=1 v=0 h=1",
                     dut_xfers - x0, seed_valid, health_fail);
        end
        repeat (10) step(1'b1, 1'b1, 1'b1);
        total++;
        if ({seed_valid, health_fail, dut_xfers - x0} !== {1'b0, 1'b1, m_xfers}) begin
            bad++;
            $display("FAIL hold_fail_park: got v=%0b h=%0b xfers=%0d want v=0 h=1 xfers=%0d",
                     seed_valid, health_fail, dut_xfers - x0, m_xfers);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_discard();
        test_hold();
        test_health();
        test_rst_mid();
        test_hold_fail();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trivium_seed_collector.md
Name: trivium_seed_collector

Overview:
- Upstream feeder for the Trivium keystream stage.
- Takes one raw TRNG bit per cycle and removes bias with a von Neumann extractor.
- Runs a repetition-count health test on the raw stream.
- Packs debiased bits into a KEY_WIDTH key and an IV_WIDTH IV, then offers the seed with a valid/ready handshake. The controller uses the seed for IV_GEN→SETUP of the Trivium stage.

Parameters:
- KEY_WIDTH, 80, key bits collected; value comes from params package.
- IV_WIDTH, 80, IV bits collected; value comes from params package.
- RCT_LIMIT, 32, count of consecutive identical raw bits that declares source failure.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- raw_bit  input  1  raw entropy bit
- raw_valid  input  1  raw_bit is valid this cycle
- seed_ready  input  1  consumer accepts seed
- seed_valid  output  1  key_/iv_ hold a complete seed
- key_  output  KEY_WIDTH  collected key
- iv_  output  IV_WIDTH  collected IV
- health_fail  output  1  sticky source-failure flag

Behaviour:
- Reset values: key_=0, iv_=0, seed_valid=0, health_fail=0, state=COLLECT_KEY, bit counter=0, pair flag=0, run length=0.
- All outputs are registered.
- Pairing rule:
  - A raw_valid beat with pair flag=0 latches the bit and sets the flag.
  - The next raw_valid beat completes the pair and clears the flag.
  - Pair 01 emits 0; pair 10 emits 1; pairs 00 and 11 emit nothing.
  - Beats where raw_valid=0 are ignored; there is no timeout.
- Packing: emitted bits are written LSB-first (first emitted bit goes to bit 0). The counter increments per emitted bit.
- FSM (seed_fsm_t):
  - COLLECT_KEY: emitted bits go into key_. When bit KEY_WIDTH-1 is written, go to COLLECT_IV and set counter=0.
  - COLLECT_IV: emitted bits go into iv_. When bit IV_WIDTH-1 is written, go to HOLD.
  - HOLD:
    - seed_valid=1, starting the cycle after the edge that wrote the final IV bit.
    - key_ and iv_ are stable.
    - Raw bits feed the health test only; the pair flag is held at 0.
    - seed_valid && seed_ready: handshake completes. Next cycle seed_valid=0, state=COLLECT_KEY, counter=0. key_/iv_ keep old values until overwritten bit by bit.
  - FAIL: seed_valid=0; no collection. Exit only by rst.
- Health test:
  - Runs on every raw_valid beat in every state except FAIL.
  - run length = 1 on the first bit and whenever the bit differs from the previous raw bit; otherwise it increments, saturating at RCT_LIMIT.
  - When run length reaches RCT_LIMIT: health_fail=1 from the next cycle, sticky until rst. State goes to FAIL and partial collection is discarded.
- Simultaneous events:
  - In HOLD, seed_ready and health failure on the same edge: the handshake counts as completed, then the state goes to FAIL.
  - In COLLECT_IV, the final IV bit and a health failure on the same edge: FAIL wins and seed_valid never rises.
- seed_valid never drops without a handshake, except on failure or rst.
- rst mid-operation restores all reset values. A full KEY_WIDTH+IV_WIDTH debiased bits are needed again.

Decomposition:
- params package: KEY_WIDTH, IV_WIDTH, RCT_LIMIT.
- le_types package: seed_fsm_t {COLLECT_KEY, COLLECT_IV, HOLD, FAIL}.
- Sub-module vn_extractor: pair flag plus first-bit latch. Inputs raw_bit/raw_valid/flush; outputs out_bit/out_valid. The top instantiates it once; the health test and FSM stay in the top.

Test Plan:
- Stream 80 pairs "01" then 80 pairs "10", raw_valid=1 every cycle (320 raw bits, max run length 2) -> seed_valid=1 one cycle after the 320th bit; key_=80'h0, iv_=all ones; health_fail=0.
- Interleave 20 "00"/"11" pairs between the first 10 "10" pairs -> they are discarded; key_[9:0]=10'h3FF, counter=10.
- Complete a seed, hold seed_ready=0 for 50 cycles while raw bits continue -> key_/iv_ unchanged, seed_valid stays 1. Raise seed_ready -> seed_valid=0 next cycle, a new collection starts.
- 31 consecutive 1s, then 0 -> health_fail stays 0. Then 32 consecutive 0s -> health_fail=1 on the cycle after the 32nd; seed_valid stays 0 forever; rst clears health_fail.
- Pulse rst after 100 debiased bits -> all outputs 0; seed_valid rises only after a further 160 debiased bits.
- In HOLD, assert seed_ready on the same edge that the 32nd identical raw bit arrives -> one transfer completes, then seed_valid=0, health_fail=1, state FAIL.
